// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Sequential ALU with single-cycle ops plus bit-serial shift/multiply.
//  Revision : 1.0
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [1:0]       SHIFT_MODE,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

    localparam int             c_cnt_w  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);
    localparam logic [2:0]     c_op_fwd = 3'd0;
    localparam logic [2:0]     c_op_add = 3'd1;
    localparam logic [2:0]     c_op_and = 3'd2;
    localparam logic [2:0]     c_op_or  = 3'd3;
    localparam logic [2:0]     c_op_shf = 3'd4;
    localparam logic [2:0]     c_op_mul = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_is_mul;
    logic [1:0]             r_mode;
    logic [WIDTH-1:0]       r_work;
    logic [2*WIDTH-1:0]     r_prod;
    logic [c_cnt_w-1:0]     r_cnt;

    logic [c_cnt_w-1:0]     w_k;
    logic                   w_long;
    logic [WIDTH-1:0]       w_imm_res;
    logic                   w_imm_cy;
    logic [WIDTH-1:0]       w_sh_res;
    logic                   w_sh_out;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_prod_next;
    logic [WIDTH-1:0]       w_fin_res;
    logic                   w_fin_cy;

    // Shift count: saturate at WIDTH for true shifts, wrap for rotate.
    always_comb begin
        w_k = '0;
        if (SHIFT_MODE == 2'b11)
            w_k = c_cnt_w'(DATA2 % c_width);
        else if (DATA2 >= c_width)
            w_k = c_cnt_w'(c_width);
        else
            w_k = c_cnt_w'(DATA2);
    end

    assign w_long = (SELECT == c_op_mul) || ((SELECT == c_op_shf) && (w_k != '0));

    always_comb begin
        w_imm_res = '0;
        w_imm_cy  = 1'b0;
        case (SELECT)
            c_op_fwd: w_imm_res = DATA2;
            c_op_add: {w_imm_cy, w_imm_res} = {1'b0, DATA1} + {1'b0, DATA2};
            c_op_and: w_imm_res = DATA1 & DATA2;
            c_op_or:  w_imm_res = DATA1 | DATA2;
            c_op_shf: w_imm_res = DATA1;
            default:  w_imm_res = '0;
        endcase
    end

    always_comb begin
        w_sh_res = '0;
        w_sh_out = 1'b0;
        case (r_mode)
            2'b00: begin
                w_sh_res = {r_work[WIDTH-2:0], 1'b0};
                w_sh_out = r_work[WIDTH-1];
            end
            2'b01: begin
                w_sh_res = {1'b0, r_work[WIDTH-1:1]};
                w_sh_out = r_work[0];
            end
            2'b10: begin
                w_sh_res = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_sh_out = r_work[0];
            end
            default: begin
                w_sh_res = {r_work[0], r_work[WIDTH-1:1]};
                w_sh_out = r_work[0];
            end
        endcase
    end

    // Shift-add step: multiplier sits in the low half and drains out the bottom.
    assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_work} : '0);
    assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};

    assign w_fin_res = r_is_mul ? w_prod_next[WIDTH-1:0] : w_sh_res;
    assign w_fin_cy  = r_is_mul ? (|w_prod_next[2*WIDTH-1:WIDTH]) : w_sh_out;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_is_mul <= 1'b0;
            r_mode   <= '0;
            r_work   <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            RESULT   <= '0;
            ZERO     <= 1'b0;
            CARRY    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_is_mul <= (SELECT == c_op_mul);
                        r_mode   <= SHIFT_MODE;
                        r_work   <= DATA1;
                        r_prod   <= {{WIDTH{1'b0}}, DATA2};
                        if (w_long) begin
                            r_cnt   <= (SELECT == c_op_mul) ? c_cnt_w'(c_width) : w_k;
                            r_state <= S_EXEC;
                        end else begin
                            RESULT  <= w_imm_res;
                            ZERO    <= (w_imm_res == '0);
                            CARRY   <= w_imm_cy;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_is_mul)
                        r_prod <= w_prod_next;
                    else
                        r_work <= w_sh_res;
                    if (r_cnt == c_cnt_w'(1)) begin
                        RESULT  <= w_fin_res;
                        ZERO    <= (w_fin_res == '0);
                        CARRY   <= w_fin_cy;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY = (r_state == S_EXEC);
    assign DONE = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Directed bench for seq_alu with a per-cycle reference model.
//  Revision : 1.0
// ============================================================================
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   sel = '0;
    logic [1:0]   mode = '0;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic [W-1:0] result;
    logic         zero, carry, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .CLK(clk), .RESET(rst), .START(start), .SELECT(sel), .SHIFT_MODE(mode),
        .DATA1(d1), .DATA2(d2), .RESULT(result), .ZERO(zero), .CARRY(carry),
        .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic [7:0]   lat;
    } exp_t;

    // Expected outcome straight from the operation definitions.
    function automatic exp_t calc(input logic [2:0] s, input logic [1:0] m,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int k;
        logic [2*W-1:0] p;
        logic [W:0] sum;
        e = '0;
        e.lat = 8'd1;
        case (s)
            3'd0: e.r = b;
            3'd1: begin sum = {1'b0, a} + {1'b0, b}; e.r = sum[W-1:0]; e.c = sum[W]; end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: begin
                k = (m == 2'b11) ? (int'(b) % W) : ((int'(b) > W) ? W : int'(b));
                if (k == 0) e.r = a;
                else begin
                    e.lat = 8'(k + 1);
                    case (m)
                        2'b00: begin e.r = a << k;  e.c = a[W-k]; end
                        2'b01: begin e.r = a >> k;  e.c = a[k-1]; end
                        2'b10: begin e.r = W'($signed(a) >>> k); e.c = a[k-1]; end
                        default: begin e.r = (a >> k) | (a << (W - k)); e.c = e.r[W-1]; end
                    endcase
                end
            end
            3'd5: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.r = p[W-1:0];
                e.c = (p[2*W-1:W] != '0);
                e.lat = 8'(W + 1);
            end
            default: e.r = '0;
        endcase
        return e;
    endfunction

    int           m_pend;
    logic         m_done;
    logic [W-1:0] m_res, p_res;
    logic         m_z, m_c, p_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 0; m_done <= 1'b0;
            m_res <= '0; m_z <= 1'b0; m_c <= 1'b0;
            p_res <= '0; p_c <= 1'b0;
        end else if (m_pend > 0) begin
            m_pend <= m_pend - 1;
            m_done <= (m_pend == 1);
            if (m_pend == 1) begin
                m_res <= p_res; m_z <= (p_res == '0); m_c <= p_c;
            end
        end else if (start) begin
            automatic exp_t e;
            e = calc(sel, mode, d1, d2);
            if (e.lat == 8'd1) begin
                m_done <= 1'b1;
                m_res <= e.r; m_z <= (e.r == '0); m_c <= e.c;
            end else begin
                m_done <= 1'b0;
                m_pend <= int'(e.lat) - 1;
                p_res <= e.r; p_c <= e.c;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",   {15'd0, busy},   {15'd0, (m_pend != 0)});
            chk("cyc_done",   {15'd0, done},   {15'd0, m_done});
            chk("cyc_result", {8'd0, result},  {8'd0, m_res});
            chk("cyc_zero",   {15'd0, zero},   {15'd0, m_z});
            chk("cyc_carry",  {15'd0, carry},  {15'd0, m_c});
        end
    end

    // Issues one operation and checks its outcome against literal values.
    // Returns at the falling edge inside the DONE cycle.
    task automatic do_op(input string nm, input logic [2:0] s, input logic [1:0] m,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] xr, input logic xz, input logic xc,
                         input int xl, input int pulse_at);
        int  cnt;
        bit  seen, bsy;
        start = 1'b1; sel = s; mode = m; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        sel = 3'($urandom); mode = 2'($urandom); d1 = W'($urandom); d2 = W'($urandom);
        cnt = 1; seen = 1'b0; bsy = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            if (busy) bsy = 1'b1;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cnt++;
                start = (cnt == pulse_at);
                if (start) begin sel = 3'd1; d1 = 8'h01; d2 = 8'h01; end
            end
        end
        start = 1'b0;
        if (!seen) chk({nm, "_timeout"}, 16'd0, 16'd1);
        chk({nm, "_lat"},    16'(cnt), 16'(xl));
        chk({nm, "_result"}, {8'd0, result}, {8'd0, xr});
        chk({nm, "_zero"},   {15'd0, zero},  {15'd0, xz});
        chk({nm, "_carry"},  {15'd0, carry}, {15'd0, xc});
        chk({nm, "_busy"},   {15'd0, bsy},   {15'd0, (xl > 1)});
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    initial begin
        int dcount;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", {8'd0, result}, 16'd0);
        chk("reset_flags",  {12'd0, zero, carry, busy, done}, 16'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        gap();

        do_op("add_wrap",  3'd1, 2'd0, 8'hF0, 8'h10, 8'h00, 1'b1, 1'b1, 1, 0); gap();
        do_op("shl3",      3'd4, 2'd0, 8'h81, 8'd3,  8'h08, 1'b0, 1'b0, 4, 0); gap();
        do_op("asr9",      3'd4, 2'd2, 8'h90, 8'd9,  8'hFF, 1'b0, 1'b1, 9, 0); gap();
        do_op("ror10",     3'd4, 2'd3, 8'h01, 8'd10, 8'h40, 1'b0, 1'b0, 3, 0); gap();
        do_op("mul_ign",   3'd5, 2'd0, 8'h12, 8'h10, 8'h20, 1'b0, 1'b1, 9, 3); gap();
        do_op("fwd",       3'd0, 2'd0, 8'hC3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1, 0); gap();
        do_op("and",       3'd2, 2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1, 0); gap();
        do_op("rsvd6",     3'd6, 2'd0, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1, 0); gap();
        do_op("shr0",      3'd4, 2'd1, 8'hA5, 8'd0,  8'hA5, 1'b0, 1'b0, 1, 0); gap();
        do_op("rot8",      3'd4, 2'd3, 8'h3C, 8'd8,  8'h3C, 1'b0, 1'b0, 1, 0); gap();
        do_op("shl200",    3'd4, 2'd0, 8'h81, 8'd200, 8'h00, 1'b1, 1'b1, 9, 0); gap();
        do_op("mul_ff",    3'd5, 2'd0, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 9, 0); gap();
        do_op("mul_zero",  3'd5, 2'd0, 8'h00, 8'h37, 8'h00, 1'b1, 1'b0, 9, 0); gap();
        do_op("add_b2b",   3'd1, 2'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1, 0); #1;
        do_op("shr_b2b",   3'd4, 2'd1, 8'h03, 8'd1,  8'h01, 1'b0, 1'b1, 2, 0); #1;
        do_op("rsvd7_b2b", 3'd7, 2'd0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1, 0); gap();
        do_op("or",        3'd3, 2'd0, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1, 0); gap();

        // Abort a multiply in its fourth EXEC cycle.
        start = 1'b1; sel = 3'd5; d1 = 8'h12; d2 = 8'h10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy",   {15'd0, busy},  16'd0);
        chk("abort_done",   {15'd0, done},  16'd0);
        chk("abort_result", {8'd0, result}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 16'(dcount), 16'd0);
        gap();
        do_op("add_after_rst", 3'd1, 2'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1, 0); gap();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be >= 2.
REQ-002 Port CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 Port RESET  input  1  reset; it SHALL be asynchronous and active-high.
REQ-004 Port START  input  1  request; sampled only in IDLE or DONE state.
REQ-005 Port SELECT  input  3  opcode: 000 FORWARD(DATA2), 001 ADD, 010 AND, 011 OR, 100 SHIFT, 101 MULT, 110/111 reserved.
REQ-006 Port SHIFT_MODE  input  2  for SHIFT: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-007 Port DATA1  input  WIDTH  first operand (shift source, multiplicand).
REQ-008 Port DATA2  input  WIDTH  second operand (unsigned shift amount, multiplier).
REQ-009 Port RESULT  output  WIDTH  registered result; held until the next completion.
REQ-010 Port ZERO  output  1  registered; 1 when RESULT == 0, updated together with RESULT.
REQ-011 Port CARRY  output  1  registered status flag; updated together with RESULT.
REQ-012 Port BUSY  output  1  high while in EXEC state.
REQ-013 Port DONE  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, DONE.
REQ-015 Start edge: the edge where START=1 in IDLE or DONE; it SHALL latch SELECT, SHIFT_MODE, DATA1 and DATA2.
REQ-016 Latched operands SHALL be used for the whole operation; input changes after the start edge SHALL have no effect.
REQ-017 Latency L: DONE SHALL be high in the cycle after the L-th edge following the start edge; RESULT, ZERO and CARRY SHALL be valid in that same cycle.
REQ-018 FORWARD, ADD, AND, OR and reserved opcodes: start edge -> DONE, L=1, BUSY never asserted.
REQ-019 ADD result SHALL be (DATA1+DATA2) mod 2^WIDTH, with CARRY = bit WIDTH of the sum.
REQ-020 FORWARD, AND and OR SHALL set CARRY=0.
REQ-021 Reserved opcodes SHALL produce RESULT=0, ZERO=1, CARRY=0.
REQ-022 SHIFT count k: for modes 00/01/10, k = min(DATA2, WIDTH); for rotate, k = DATA2 mod WIDTH.
REQ-023 SHIFT by k=0: start edge -> DONE, L=1, RESULT=DATA1, CARRY=0.
REQ-024 SHIFT by k>0: start edge -> EXEC; one bit position per EXEC cycle; after k EXEC edges -> DONE; L = k+1.
REQ-025 SHIFT CARRY SHALL equal the last bit shifted or rotated out.
REQ-026 Arithmetic right shift SHALL replicate the sign bit (bit WIDTH-1).
REQ-027 MULT SHALL use a 2*WIDTH-bit product register with shift-add, one multiplier bit per EXEC cycle; WIDTH EXEC cycles; L = WIDTH+1.
REQ-028 MULT RESULT SHALL be product[WIDTH-1:0], with CARRY=1 iff product[2*WIDTH-1:WIDTH] != 0.
REQ-029 START while BUSY SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-030 DONE state SHALL last exactly one cycle, then go to IDLE; START=1 in DONE SHALL begin a new operation on that edge (back-to-back).
REQ-031 RESULT, ZERO and CARRY SHALL change only on the edge that enters DONE.

Reset
REQ-032 RESET=1 SHALL immediately force IDLE, RESULT=0, ZERO=0, CARRY=0, BUSY=0, DONE=0, and clear internal counters and registers.
REQ-033 RESET during EXEC SHALL abort the operation, with no DONE pulse afterwards.
REQ-034 After RESET deasserts, the first start edge SHALL be accepted normally.

Verification (WIDTH=8)
REQ-035 ADD 0xF0+0x10 -> RESULT=0x00, ZERO=1, CARRY=1, DONE 1 cycle after start, BUSY never high.
REQ-036 SHIFT mode 00, 0x81 by 3 -> BUSY high 3 cycles, then DONE with RESULT=0x08, CARRY=0 (L=4).
REQ-037 SHIFT mode 10, 0x90 by 9 -> k capped to 8; RESULT=0xFF, CARRY=1, L=9.
REQ-038 SHIFT mode 11, 0x01 by 10 -> k=2; RESULT=0x40, CARRY=0, L=3.
REQ-039 MULT 0x12*0x10 -> RESULT=0x20, CARRY=1, ZERO=0, L=9; a START pulse at EXEC cycle 3 is ignored.
REQ-040 MULT started, RESET pulsed at EXEC cycle 4 -> BUSY=0, RESULT=0 immediately; no DONE; next ADD 0x01+0x02 -> RESULT=0x03 with L=1.
